// File: rtl/ibex_ex_wb_buffer_pkg.sv
// Shared types for the EX->WB result buffer and its forwarding selector.
package ibex_ex_wb_buffer_pkg;

  localparam int unsigned EX_WB_DATA_W = 32;
  localparam int unsigned RF_ADDR_W    = 5;

  // One completed EX result waiting for register-file writeback.
  typedef struct packed {
    logic [EX_WB_DATA_W-1:0] result;
    logic [RF_ADDR_W-1:0]    rd_addr;
    logic                    we;
    logic                    vxsat;
  } ex_wb_entry_t;

  // Pointer width with an extra wrap bit so full and empty stay distinct.
  function automatic int unsigned ex_wb_ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ibex_ex_wb_fwd_sel.sv
// Youngest-match forwarding selector over the buffered results for one source register.
module ibex_ex_wb_fwd_sel
  import ibex_ex_wb_buffer_pkg::*;
#(
  parameter  int unsigned Depth = 2,
  localparam int unsigned AW    = $clog2(Depth)
) (
  input  logic [Depth-1:0]                   i_valid,
  input  logic [Depth-1:0]                   i_we,
  input  logic [Depth-1:0][RF_ADDR_W-1:0]    i_rd_addr,
  input  logic [Depth-1:0][EX_WB_DATA_W-1:0] i_data,
  input  logic [AW-1:0]                      i_wr_idx,
  input  logic [RF_ADDR_W-1:0]               i_rs_addr,
  output logic                               o_hit,
  output logic [EX_WB_DATA_W-1:0]            o_data
);

  logic [AW-1:0] w_idx;

  // Walk from oldest to youngest slot so the youngest match overwrites older ones; x0 never hits.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int k = Depth - 1; k >= 0; k--) begin
      w_idx = i_wr_idx - AW'(k + 1);
      if (i_valid[w_idx] && i_we[w_idx] && (i_rd_addr[w_idx] == i_rs_addr) &&
          (i_rs_addr != '0)) begin
        o_hit  = 1'b1;
        o_data = i_data[w_idx];
      end
    end
  end

endmodule

// File: rtl/ibex_ex_wb_buffer.sv
// In-order result FIFO between EX and writeback with operand forwarding and sticky vxsat.
module ibex_ex_wb_buffer
  import ibex_ex_wb_buffer_pkg::*;
#(
  parameter int unsigned Depth    = 2,
  parameter bit          ResetAll = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          ex_valid_i,
  output logic                          ex_ready_o,
  input  logic [EX_WB_DATA_W-1:0]       ex_result_i,
  input  logic [RF_ADDR_W-1:0]          ex_rd_addr_i,
  input  logic                          ex_rd_we_i,
  input  logic                          ex_vxsat_set_i,
  output logic                          wb_valid_o,
  input  logic                          wb_ready_i,
  output logic [EX_WB_DATA_W-1:0]       wb_result_o,
  output logic [RF_ADDR_W-1:0]          wb_rd_addr_o,
  output logic                          wb_rd_we_o,
  input  logic                          flush_i,
  input  logic [1:0][RF_ADDR_W-1:0]     fwd_rs_addr_i,
  output logic [1:0]                    fwd_hit_o,
  output logic [1:0][EX_WB_DATA_W-1:0]  fwd_data_o,
  input  logic                          vxsat_we_i,
  input  logic                          vxsat_wdata_i,
  output logic                          vxsat_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = ex_wb_ptr_w(Depth);

  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [Depth-1:0] r_valid;
  ex_wb_entry_t   r_entries [Depth];
  logic           r_vxsat;

  logic [PW-1:0]  w_count;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic [AW-1:0]  w_wr_idx;
  logic [AW-1:0]  w_rd_idx;
  ex_wb_entry_t   w_new;
  ex_wb_entry_t   w_head;

  logic [Depth-1:0]                   w_ent_we;
  logic [Depth-1:0][RF_ADDR_W-1:0]    w_ent_rd;
  logic [Depth-1:0][EX_WB_DATA_W-1:0] w_ent_data;

  // Occupancy comes from registered pointers only, so ex_ready_o never depends on wb_ready_i.
  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_full   = (w_count == PW'(Depth));
  assign w_empty  = (w_count == '0);
  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];

  assign ex_ready_o = ~w_full;
  assign wb_valid_o = ~w_empty;
  assign w_push     = ex_valid_i & ~w_full & ~flush_i;
  assign w_pop      = ~w_empty & wb_ready_i & ~flush_i;

  assign w_new.result  = ex_result_i;
  assign w_new.rd_addr = ex_rd_addr_i;
  assign w_new.we      = ex_rd_we_i;
  assign w_new.vxsat   = ex_vxsat_set_i;

  assign w_head       = r_entries[w_rd_idx];
  assign wb_result_o  = w_head.result;
  assign wb_rd_addr_o = w_head.rd_addr;
  assign wb_rd_we_o   = w_head.we & wb_valid_o;
  assign vxsat_o      = r_vxsat;

  // Pointer and per-entry valid tracking; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr           <= r_wr_ptr + PW'(1);
        r_valid[w_wr_idx]  <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr           <= r_rd_ptr + PW'(1);
        r_valid[w_rd_idx]  <= 1'b0;
      end
    end
  end

  // Sticky vxsat: a CSR write is younger than the popping entry, so it takes priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vxsat <= 1'b0;
    end else if (vxsat_we_i) begin
      r_vxsat <= vxsat_wdata_i;
    end else if (w_pop && w_head.vxsat) begin
      r_vxsat <= 1'b1;
    end
  end

  // Entry storage; reset only when ResetAll is set, otherwise plain enabled flops.
  if (ResetAll) begin : g_store_rst
    // Write the incoming result into the slot at the write pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < Depth; i++) begin
          r_entries[i] <= '0;
        end
      end else if (w_push) begin
        r_entries[w_wr_idx] <= w_new;
      end
    end
  end else begin : g_store_norst
    // Write the incoming result into the slot at the write pointer.
    always_ff @(posedge clk_i) begin
      if (w_push) begin
        r_entries[w_wr_idx] <= w_new;
      end
    end
  end

  // Flatten stored fields for the forwarding selectors.
  always_comb begin
    w_ent_we   = '0;
    w_ent_rd   = '0;
    w_ent_data = '0;
    for (int i = 0; i < Depth; i++) begin
      w_ent_we[i]   = r_entries[i].we;
      w_ent_rd[i]   = r_entries[i].rd_addr;
      w_ent_data[i] = r_entries[i].result;
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_fwd
    ibex_ex_wb_fwd_sel #(
      .Depth(Depth)
    ) u_fwd_sel (
      .i_valid   (r_valid),
      .i_we      (w_ent_we),
      .i_rd_addr (w_ent_rd),
      .i_data    (w_ent_data),
      .i_wr_idx  (w_wr_idx),
      .i_rs_addr (fwd_rs_addr_i[s]),
      .o_hit     (fwd_hit_o[s]),
      .o_data    (fwd_data_o[s])
    );
  end

endmodule

// File: tb/tb_ibex_ex_wb_buffer.sv
// Randomized and directed bench for ibex_ex_wb_buffer against a queue-based reference model.
module tb_ibex_ex_wb_buffer;

  localparam int unsigned DEPTH = 2;

  logic              clk;
  logic              rst_n;
  logic              ex_valid;
  logic              ex_ready;
  logic [31:0]       ex_result;
  logic [4:0]        ex_rd_addr;
  logic              ex_rd_we;
  logic              ex_vxsat_set;
  logic              wb_valid;
  logic              wb_ready;
  logic [31:0]       wb_result;
  logic [4:0]        wb_rd_addr;
  logic              wb_rd_we;
  logic              flush;
  logic [1:0][4:0]   fwd_rs_addr;
  logic [1:0]        fwd_hit;
  logic [1:0][31:0]  fwd_data;
  logic              vxsat_we;
  logic              vxsat_wdata;
  logic              vxsat;

  ibex_ex_wb_buffer #(
    .Depth(DEPTH),
    .ResetAll(1'b0)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .ex_valid_i     (ex_valid),
    .ex_ready_o     (ex_ready),
    .ex_result_i    (ex_result),
    .ex_rd_addr_i   (ex_rd_addr),
    .ex_rd_we_i     (ex_rd_we),
    .ex_vxsat_set_i (ex_vxsat_set),
    .wb_valid_o     (wb_valid),
    .wb_ready_i     (wb_ready),
    .wb_result_o    (wb_result),
    .wb_rd_addr_o   (wb_rd_addr),
    .wb_rd_we_o     (wb_rd_we),
    .flush_i        (flush),
    .fwd_rs_addr_i  (fwd_rs_addr),
    .fwd_hit_o      (fwd_hit),
    .fwd_data_o     (fwd_data),
    .vxsat_we_i     (vxsat_we),
    .vxsat_wdata_i  (vxsat_wdata),
    .vxsat_o        (vxsat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic        vs;
  } ent_t;

  ent_t q[$];
  bit   m_vxsat;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare every output against the model's current contents.
  task automatic check_model();
    logic       hit;
    logic [31:0] data;
    chk("wb_valid", 32'(wb_valid), 32'(q.size() != 0));
    chk("ex_ready", 32'(ex_ready), 32'(q.size() != DEPTH));
    chk("vxsat", 32'(vxsat), 32'(m_vxsat));
    if (q.size() != 0) begin
      chk("wb_result", wb_result, q[0].res);
      chk("wb_rd_addr", 32'(wb_rd_addr), 32'(q[0].rd));
      chk("wb_rd_we", 32'(wb_rd_we), 32'(q[0].we));
    end else begin
      chk("wb_rd_we_empty", 32'(wb_rd_we), 32'(0));
    end
    for (int s = 0; s < 2; s++) begin
      hit  = 1'b0;
      data = '0;
      if (fwd_rs_addr[s] != 0) begin
        for (int j = q.size() - 1; j >= 0; j--) begin
          if (q[j].we && q[j].rd == fwd_rs_addr[s]) begin
            hit  = 1'b1;
            data = q[j].res;
            break;
          end
        end
      end
      chk($sformatf("fwd_hit%0d", s), 32'(fwd_hit[s]), 32'(hit));
      chk($sformatf("fwd_data%0d", s), fwd_data[s], data);
    end
  endtask

  // One clock cycle: drive at negedge, check, advance model, return just after posedge.
  task automatic step(input logic ev, input logic [31:0] res, input logic [4:0] rd,
                      input logic we, input logic vs, input logic wr, input logic fl,
                      input logic [4:0] rs0, input logic [4:0] rs1,
                      input logic vwe, input logic vwd);
    bit   pop;
    bit   push;
    bit   popvs;
    ent_t e;
    @(negedge clk);
    ex_valid = ev; ex_result = res; ex_rd_addr = rd; ex_rd_we = we; ex_vxsat_set = vs;
    wb_ready = wr; flush = fl; fwd_rs_addr[0] = rs0; fwd_rs_addr[1] = rs1;
    vxsat_we = vwe; vxsat_wdata = vwd;
    #1;
    check_model();
    pop   = (q.size() != 0) && wr && !fl;
    push  = ev && (q.size() != DEPTH) && !fl;
    popvs = pop ? q[0].vs : 1'b0;
    e.res = res; e.rd = rd; e.we = we; e.vs = vs;
    if (fl) begin
      q.delete();
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
    end
    if (vwe)        m_vxsat = vwd;
    else if (popvs) m_vxsat = 1'b1;
    @(posedge clk);
    #1;
    ex_valid = 1'b0; wb_ready = 1'b0; flush = 1'b0; vxsat_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 0; ex_result = 0; ex_rd_addr = 0; ex_rd_we = 0; ex_vxsat_set = 0;
    wb_ready = 0; flush = 0; fwd_rs_addr = '0; vxsat_we = 0; vxsat_wdata = 0;
    m_vxsat = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_ex_ready", 32'(ex_ready), 1);
    chk("rst_fwd_hit", 32'(fwd_hit), 0);
    chk("rst_vxsat", 32'(vxsat), 0);

    // Fill to full, then drain in order.
    step(1, 32'h11, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h22, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("full_ex_ready", 32'(ex_ready), 0);
    chk("full_head", wb_result, 32'h11);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("after_pop_ex_ready", 32'(ex_ready), 1);
    chk("after_pop_head", wb_result, 32'h22);
    chk("after_pop_rd", 32'(wb_rd_addr), 6);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("drained", 32'(wb_valid), 0);

    // Continuous push/pop through pointer wrap.
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h100 + 32'(i), 5'(i + 1), 1, 0, 1, 0, 0, 0, 0, 0);
      chk("stream_valid", 32'(wb_valid), 1);
      chk("stream_head", wb_result, 32'h100 + 32'(i));
    end
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Forwarding: youngest of two x7 writers wins, x0 never hits.
    step(1, 32'hA, 7, 1, 0, 0, 0, 7, 0, 0, 0);
    step(1, 32'hB, 7, 1, 0, 0, 0, 7, 0, 0, 0);
    chk("fwd_hit_vec", 32'(fwd_hit), 32'b01);
    chk("fwd_young", fwd_data[0], 32'hB);
    step(0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0);
    step(1, 32'hC, 8, 0, 0, 0, 0, 8, 8, 0, 0);
    chk("fwd_we0_nohit", 32'(fwd_hit), 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // vxsat: pop sets it, CSR write in the same cycle overrides.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 32'h5, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("vxsat_set", 32'(vxsat), 1);
    step(1, 32'h6, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    chk("vxsat_csr_wins", 32'(vxsat), 0);

    // Flush discards entries, the pending vxsat, and the flush-cycle push.
    step(1, 32'h1, 9, 1, 1, 0, 0, 9, 10, 0, 0);
    step(1, 32'h2, 10, 1, 0, 0, 0, 9, 10, 0, 0);
    step(1, 32'h3, 11, 1, 1, 0, 1, 9, 11, 0, 0);
    chk("flush_valid", 32'(wb_valid), 0);
    chk("flush_fwd", 32'(fwd_hit), 0);
    chk("flush_vxsat", 32'(vxsat), 0);
    step(0, 0, 0, 0, 0, 1, 0, 11, 9, 0, 0);

    // Asynchronous reset while two entries are queued.
    step(1, 32'h7, 12, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 32'h8, 13, 1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 32'h9, 14, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_full", 32'(ex_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("async_wb_valid", 32'(wb_valid), 0);
    chk("async_vxsat", 32'(vxsat), 0);
    chk("async_ex_ready", 32'(ex_ready), 1);
    q.delete();
    m_vxsat = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
